// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter slice: FSM encoding,
// module-select codes and the idle bus address.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Module-select codes carried in address[15:12]
  localparam logic [3:0] MOD_MEMORY      = 4'd0;
  localparam logic [3:0] MOD_INSTRUCTION = 4'd1;
  localparam logic [3:0] MOD_MATRIX_ALU  = 4'd2;
  localparam logic [3:0] MOD_INTEGER_ALU = 4'd3;
  localparam logic [3:0] MOD_INTERNAL    = 4'd4;
  localparam logic [3:0] MOD_EXE_ENGINE  = 4'd5;

  localparam logic [15:0] IDLE_ADDR = {MOD_EXE_ENGINE, 12'h000};

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requesting index strictly after
// last_winner, wrapping around; one-hot result plus valid.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_winner) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with IDLE/GRANT/RELEASE FSM.
// Define ARB_TIMEOUT_EN to enable the HOLD_MAX forced-release watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 256,
  parameter int HOLD_MAX = 16
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*16-1:0]     addr_in,
  input  logic [NUM_REQ-1:0]        nRead_in,
  input  logic [NUM_REQ-1:0]        nWrite_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [15:0]               address,
  output logic                      nRead,
  output logic                      nWrite,
  output logic [DATA_W-1:0]         DataOut,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = ARB_IDLE;
  localparam logic [1:0] S_GRANT   = ARB_GRANT;
  localparam logic [1:0] S_RELEASE = ARB_RELEASE;

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               timeout_hit;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_select (
    .req         (req_eff),
    .last_winner (last_winner),
    .winner      (winner),
    .valid       (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner[i]) win_idx = IDX_W'(i);
  end

  // RELEASE re-arbitrates directly, so it shares the IDLE transition
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= S_IDLE;
      gnt         <= '0;
      grant_idx   <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_GRANT: begin
          if (!req[grant_idx] || timeout_hit) begin
            state <= S_RELEASE;
            gnt   <= '0;
          end
        end
        default: begin
          if (win_valid) begin
            state       <= S_GRANT;
            gnt         <= winner;
            grant_idx   <= win_idx;
            last_winner <= win_idx;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] blocked;
  logic               timeout_q;

  assign timeout_hit = (state == S_GRANT) && req[grant_idx] &&
                       (hold_cnt == CNT_W'(HOLD_MAX - 1));
  // A timed-out requester stays out of arbitration until it drops req
  assign req_eff     = req & ~blocked;
  assign timeout_err = timeout_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      hold_cnt  <= '0;
      blocked   <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt <= (state == S_GRANT && !timeout_hit) ? hold_cnt + 1'b1 : '0;
      blocked  <= blocked & req;
      if (timeout_hit) begin
        blocked[grant_idx] <= 1'b1;
        timeout_q          <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req_eff     = req;
  assign timeout_err = 1'b0;
`endif

  // Bus mux: zero-latency pass-through of the granted requester only
  always_comb begin
    address = IDLE_ADDR;
    nRead   = 1'b1;
    nWrite  = 1'b1;
    DataOut = '0;
    if (state == S_GRANT) begin
      address = addr_in[grant_idx*16 +: 16];
      nRead   = nRead_in[grant_idx];
      nWrite  = nWrite_in[grant_idx] | ~nRead_in[grant_idx];
      DataOut = data_in[grant_idx*DATA_W +: DATA_W];
    end
  end

  assign busy = |gnt;

endmodule
